// File: rtl/clock_alarm_pkg.sv
// rtl/clock_alarm_pkg.sv - mode encoding shared by the clock/alarm controller
package clock_alarm_pkg;

   localparam logic [1:0] MODE_RUN     = 2'd0;
   localparam logic [1:0] MODE_SET_CLK = 2'd1;
   localparam logic [1:0] MODE_SET_ALM = 2'd2;
   localparam logic [1:0] MODE_RINGING = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN     = MODE_RUN,
      ST_SET_CLK = MODE_SET_CLK,
      ST_SET_ALM = MODE_SET_ALM,
      ST_RINGING = MODE_RINGING
   } state_t;

endpackage

// File: rtl/clock_alarm_ctrl_if.sv
// rtl/clock_alarm_ctrl_if.sv - board inputs and datapath controls of the clock/alarm controller
interface clock_alarm_ctrl_if;

   logic       tick_1hz;
   logic       Set_Clock;
   logic       Set_Alarm;
   logic       MIN;
   logic       HR;
   logic       Alarm_Off;
   logic       time_match;
   logic [1:0] mode;
   logic       run_en;
   logic       sec_clr;
   logic       inc_min_clk;
   logic       inc_hr_clk;
   logic       inc_min_alm;
   logic       inc_hr_alm;
   logic       Alarm_Out;

   modport master (
      output tick_1hz, Set_Clock, Set_Alarm, MIN, HR, Alarm_Off, time_match,
      input  mode, run_en, sec_clr, inc_min_clk, inc_hr_clk, inc_min_alm, inc_hr_alm, Alarm_Out
   );

   modport slave (
      input  tick_1hz, Set_Clock, Set_Alarm, MIN, HR, Alarm_Off, time_match,
      output mode, run_en, sec_clr, inc_min_clk, inc_hr_clk, inc_min_alm, inc_hr_alm, Alarm_Out
   );

endinterface

// File: rtl/clock_alarm_ctrl_btn_conditioner.sv
// rtl/clock_alarm_ctrl_btn_conditioner.sv - synchroniser, debounce and press/auto-repeat strobe
// Level follows the input 2 + DEBOUNCE_CYC cycles after a stable change.
module btn_conditioner #(
   parameter int DEBOUNCE_CYC = 100000,
   parameter bit REPEAT_EN    = 1'b0,
   parameter int REPEAT_DLY   = 2500000,
   parameter int REPEAT_CYC   = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic press
);

   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int RW = $clog2(REPEAT_DLY + REPEAT_CYC + 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] CYC_LAST = RW'(REPEAT_CYC - 1);

   logic          r_s1, r_s2, r_level, r_press, r_rep_phase;
   logic [DW-1:0] r_db_cnt;
   logic [RW-1:0] r_rep_cnt;
   logic          w_flip, w_rep_hit;

   // No repeat on the release edge itself, so a hold of exactly N cycles never gains a stray strobe.
   always_comb begin
      w_flip    = (r_s2 != r_level) && (r_db_cnt == DB_LAST);
      w_rep_hit = REPEAT_EN && r_level && !w_flip &&
                  (r_rep_cnt == (r_rep_phase ? CYC_LAST : DLY_LAST));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_level     <= 1'b0;
         r_press     <= 1'b0;
         r_rep_phase <= 1'b0;
         r_db_cnt    <= '0;
         r_rep_cnt   <= '0;
      end else begin
         r_s1 <= din;
         r_s2 <= r_s1;
         if (r_s2 == r_level) begin
            r_db_cnt <= '0;
         end else if (w_flip) begin
            r_db_cnt <= '0;
            r_level  <= r_s2;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
         r_press <= (w_flip && r_s2) || w_rep_hit;
         if (!r_level || w_flip) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
         end else if (w_rep_hit) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
         end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
         end
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/clock_alarm_ctrl.sv
// rtl/clock_alarm_ctrl.sv - RUN / SET_CLK / SET_ALM / RINGING mode controller
// Conditions board inputs and emits registered increment strobes and the buzzer drive.
module clock_alarm_ctrl
   import clock_alarm_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 100000,
   parameter int REPEAT_DLY   = 2500000,
   parameter int REPEAT_CYC   = 1000000,
   parameter int RING_SEC     = 60
) (
   input logic               clk,
   input logic               reset,
   clock_alarm_ctrl_if.slave bus
);

   localparam int RCW = $clog2(RING_SEC + 1);
   localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SEC);

   state_t         r_state, w_next;
   logic           r_match_q, r_alarm, r_sec_clr;
   logic           r_inc_min_clk, r_inc_hr_clk, r_inc_min_alm, r_inc_hr_alm;
   logic [RCW-1:0] r_ring_cnt;
   logic           w_setc, w_seta, w_min_p, w_hr_p, w_off_p;
   logic           w_setc_p, w_seta_p, w_min_lvl, w_hr_lvl, w_off_lvl;
   logic           w_unused;

   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
      u_setc (.clk(clk), .reset(reset), .din(bus.Set_Clock), .level(w_setc), .press(w_setc_p));
   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
      u_seta (.clk(clk), .reset(reset), .din(bus.Set_Alarm), .level(w_seta), .press(w_seta_p));
   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
      u_min (.clk(clk), .reset(reset), .din(bus.MIN), .level(w_min_lvl), .press(w_min_p));
   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
      u_hr (.clk(clk), .reset(reset), .din(bus.HR), .level(w_hr_lvl), .press(w_hr_p));
   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
      u_off (.clk(clk), .reset(reset), .din(bus.Alarm_Off), .level(w_off_lvl), .press(w_off_p));

   assign w_unused = &{w_setc_p, w_seta_p, w_min_lvl, w_hr_lvl, w_off_lvl};

   // Ringing is entered only on the rising edge of the match, never by returning into one.
   always_comb begin
      w_next = r_state;
      if (w_setc) begin
         w_next = ST_SET_CLK;
      end else if (w_seta) begin
         w_next = ST_SET_ALM;
      end else begin
         case (r_state)
            ST_RUN:     if (bus.time_match && !r_match_q) w_next = ST_RINGING;
            ST_RINGING: if (w_off_p || (r_ring_cnt == RING_LAST)) w_next = ST_RUN;
            default:    w_next = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_match_q     <= 1'b0;
         r_alarm       <= 1'b0;
         r_sec_clr     <= 1'b0;
         r_ring_cnt    <= '0;
         r_inc_min_clk <= 1'b0;
         r_inc_hr_clk  <= 1'b0;
         r_inc_min_alm <= 1'b0;
         r_inc_hr_alm  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_match_q <= bus.time_match;
         r_sec_clr <= (r_state == ST_SET_CLK) && (w_next != ST_SET_CLK);
         if (r_state != ST_RINGING) r_ring_cnt <= '0;
         else if (bus.tick_1hz)     r_ring_cnt <= r_ring_cnt + 1'b1;
         if (w_next != ST_RINGING)      r_alarm <= 1'b0;
         else if (r_state != ST_RINGING) r_alarm <= 1'b1;
         else if (bus.tick_1hz)          r_alarm <= ~r_alarm;
         r_inc_min_clk <= w_min_p && (r_state == ST_SET_CLK);
         r_inc_hr_clk  <= w_hr_p  && (r_state == ST_SET_CLK);
         r_inc_min_alm <= w_min_p && (r_state == ST_SET_ALM);
         r_inc_hr_alm  <= w_hr_p  && (r_state == ST_SET_ALM);
      end
   end

   assign bus.mode        = r_state;
   assign bus.run_en      = (r_state != ST_SET_CLK);
   assign bus.sec_clr     = r_sec_clr;
   assign bus.inc_min_clk = r_inc_min_clk;
   assign bus.inc_hr_clk  = r_inc_hr_clk;
   assign bus.inc_min_alm = r_inc_min_alm;
   assign bus.inc_hr_alm  = r_inc_hr_alm;
   assign bus.Alarm_Out   = r_alarm;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// tb/tb_clock_alarm_ctrl.sv - self-checking bench for clock_alarm_ctrl
module tb_clock_alarm_ctrl;

   localparam int D   = 4;
   localparam int DLY = 16;
   localparam int CYC = 8;
   localparam int RS  = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   n_min_clk = 0, n_hr_clk = 0, n_min_alm = 0, n_hr_alm = 0;
   int   n_sec_clr = 0, n_ring = 0, n_both = 0;

   clock_alarm_ctrl_if bus_if ();

   clock_alarm_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_DLY(DLY), .REPEAT_CYC(CYC), .RING_SEC(RS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (bus_if.inc_min_clk === 1'b1) n_min_clk++;
      if (bus_if.inc_hr_clk === 1'b1) n_hr_clk++;
      if (bus_if.inc_min_alm === 1'b1) n_min_alm++;
      if (bus_if.inc_hr_alm === 1'b1) n_hr_alm++;
      if (bus_if.sec_clr === 1'b1) n_sec_clr++;
      if (bus_if.mode === 2'd3) n_ring++;
      if (bus_if.inc_min_alm === 1'b1 && bus_if.inc_hr_alm === 1'b1) n_both++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Strobes for a button held h cycles: first press, then repeats at DLY, DLY+CYC, ... strictly inside the hold.
   function automatic int exp_presses(input int h);
      if (h < D) return 0;
      if (h <= DLY) return 1;
      return 2 + (h - DLY - 1) / CYC;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
      cyc(1);
      chk("reset_mode", int'(bus_if.mode), 0);
      chk("reset_run_en", int'(bus_if.run_en), 1);
      chk("reset_alarm", int'(bus_if.Alarm_Out), 0);
      chk("reset_strobes", int'({bus_if.inc_min_clk, bus_if.inc_hr_clk, bus_if.inc_min_alm,
                                 bus_if.inc_hr_alm, bus_if.sec_clr}), 0);
   endtask

   task automatic test_set_clock();
      int b, bh, bs, h;
      bit use_hr;
      bus_if.Set_Clock = 1'b1;
      cyc(D + 6);
      chk("setclk_mode", int'(bus_if.mode), 1);
      chk("setclk_run_en", int'(bus_if.run_en), 0);
      b = n_min_clk;
      bus_if.MIN = 1'b1; cyc(2); bus_if.MIN = 1'b0;
      cyc(D + 8);
      chk("min_glitch", n_min_clk - b, 0);
      b = n_min_clk;
      bh = n_min_alm;
      bus_if.MIN = 1'b1;
      cyc(D + 2);
      chk("min_latency_pre", int'(bus_if.inc_min_clk), 0);
      cyc(1);
      chk("min_latency_hit", int'(bus_if.inc_min_clk), 1);
      cyc(1);
      chk("min_single_cycle", int'(bus_if.inc_min_clk), 0);
      cyc(40 - (D + 4));
      bus_if.MIN = 1'b0;
      cyc(D + 6);
      chk("min_hold40_count", n_min_clk - b, exp_presses(40));
      chk("min_hold40_alm", n_min_alm - bh, 0);
      repeat (4) begin
         h = $urandom_range(D, 50);
         use_hr = 1'($urandom_range(0, 1));
         b = n_min_clk;
         bh = n_hr_clk;
         if (use_hr) bus_if.HR = 1'b1; else bus_if.MIN = 1'b1;
         cyc(h);
         bus_if.HR = 1'b0;
         bus_if.MIN = 1'b0;
         cyc(D + 6);
         chk("rand_hold_min", n_min_clk - b, use_hr ? 0 : exp_presses(h));
         chk("rand_hold_hr", n_hr_clk - bh, use_hr ? exp_presses(h) : 0);
      end
      bs = n_sec_clr;
      bus_if.Set_Clock = 1'b0;
      cyc(D + 6);
      chk("sec_clr_once", n_sec_clr - bs, 1);
      chk("setclk_exit_mode", int'(bus_if.mode), 0);
      chk("setclk_exit_run_en", int'(bus_if.run_en), 1);
   endtask

   task automatic test_set_alarm();
      int ba, bc, bb, bs, h, b0, b1, b2, b3;
      bus_if.Set_Alarm = 1'b1;
      cyc(D + 6);
      chk("setalm_mode", int'(bus_if.mode), 2);
      chk("setalm_run_en", int'(bus_if.run_en), 1);
      ba = n_hr_alm;
      bc = n_hr_clk;
      h = $urandom_range(D, DLY);
      bus_if.HR = 1'b1; cyc(h); bus_if.HR = 1'b0;
      cyc(D + 6);
      chk("hr_alm_count", n_hr_alm - ba, 1);
      chk("hr_clk_count", n_hr_clk - bc, 0);
      chk("setalm_run_en_hold", int'(bus_if.run_en), 1);
      bb = n_both;
      bus_if.MIN = 1'b1; bus_if.HR = 1'b1;
      cyc(D + 3);
      bus_if.MIN = 1'b0; bus_if.HR = 1'b0;
      cyc(D + 6);
      chk("min_hr_same_cycle", n_both - bb, 1);
      bs = n_sec_clr;
      bus_if.Set_Alarm = 1'b0;
      cyc(D + 6);
      chk("setalm_exit_mode", int'(bus_if.mode), 0);
      chk("setalm_exit_no_sec_clr", n_sec_clr - bs, 0);
      b0 = n_min_clk; b1 = n_hr_clk; b2 = n_min_alm; b3 = n_hr_alm;
      h = $urandom_range(D, 30);
      bus_if.MIN = 1'b1; bus_if.HR = 1'b1; cyc(h); bus_if.MIN = 1'b0; bus_if.HR = 1'b0;
      cyc(D + 6);
      chk("run_ignores_buttons", (n_min_clk - b0) + (n_hr_clk - b1) + (n_min_alm - b2) + (n_hr_alm - b3), 0);
   endtask

   task automatic test_ring_timeout();
      int exp_al, nr;
      bus_if.time_match = 1'b1;
      cyc(1);
      chk("ring_entry_mode", int'(bus_if.mode), 3);
      chk("ring_entry_alarm", int'(bus_if.Alarm_Out), 1);
      exp_al = 1;
      for (int i = 0; i < RS; i++) begin
         cyc($urandom_range(1, 4));
         bus_if.tick_1hz = 1'b1; cyc(1); bus_if.tick_1hz = 1'b0;
         exp_al = 1 - exp_al;
         chk("ring_toggle_alarm", int'(bus_if.Alarm_Out), exp_al);
         chk("ring_toggle_mode", int'(bus_if.mode), 3);
      end
      cyc(1);
      chk("ring_timeout_mode", int'(bus_if.mode), 0);
      chk("ring_timeout_alarm", int'(bus_if.Alarm_Out), 0);
      nr = n_ring;
      cyc(20);
      chk("no_rering", n_ring - nr, 0);
      bus_if.time_match = 1'b0;
      cyc(2);
   endtask

   task automatic test_alarm_off();
      int nr, bs;
      bus_if.time_match = 1'b1;
      cyc(2);
      chk("off_ring_mode", int'(bus_if.mode), 3);
      bus_if.Alarm_Off = 1'b1; cyc(D + 2); bus_if.Alarm_Off = 1'b0;
      cyc(2);
      chk("off_mode", int'(bus_if.mode), 0);
      chk("off_alarm", int'(bus_if.Alarm_Out), 0);
      cyc(D + 4);
      bus_if.time_match = 1'b0; cyc(2);
      bus_if.time_match = 1'b1; cyc(2);
      chk("ring2_mode", int'(bus_if.mode), 3);
      bus_if.Set_Clock = 1'b1;
      cyc(D + 4);
      chk("ring_setclk_mode", int'(bus_if.mode), 1);
      chk("ring_setclk_run_en", int'(bus_if.run_en), 0);
      chk("ring_setclk_alarm", int'(bus_if.Alarm_Out), 0);
      nr = n_ring;
      bs = n_sec_clr;
      bus_if.Set_Clock = 1'b0;
      cyc(D + 10);
      chk("exit_into_match_mode", int'(bus_if.mode), 0);
      chk("exit_into_match_no_ring", n_ring - nr, 0);
      chk("exit_into_match_sec_clr", n_sec_clr - bs, 1);
      bus_if.time_match = 1'b0;
      cyc(2);
   endtask

   task automatic test_both_and_reset();
      int b, h;
      bus_if.Set_Clock = 1'b1; bus_if.Set_Alarm = 1'b1;
      cyc(D + 6);
      chk("both_switches_mode", int'(bus_if.mode), 1);
      chk("both_switches_run_en", int'(bus_if.run_en), 0);
      bus_if.Set_Alarm = 1'b0;
      cyc(D + 6);
      chk("setclk_keeps_mode", int'(bus_if.mode), 1);
      b = n_min_clk;
      bus_if.MIN = 1'b1;
      cyc(D + 8);
      chk("hold_before_reset", n_min_clk - b, 1);
      reset = 1'b1;
      cyc(2);
      chk("mid_reset_mode", int'(bus_if.mode), 0);
      reset = 1'b0;
      bus_if.MIN = 1'b0;
      b = n_min_clk;
      cyc(40);
      chk("no_strobe_after_reset", n_min_clk - b, 0);
      chk("reset_then_setclk_mode", int'(bus_if.mode), 1);
      h = $urandom_range(D, DLY);
      bus_if.MIN = 1'b1; cyc(h); bus_if.MIN = 1'b0;
      cyc(D + 6);
      chk("fresh_press_after_reset", n_min_clk - b, 1);
      bus_if.Set_Clock = 1'b0;
      cyc(D + 6);
   endtask

   initial begin
      bus_if.tick_1hz = 1'b0;
      bus_if.Set_Clock = 1'b0;
      bus_if.Set_Alarm = 1'b0;
      bus_if.MIN = 1'b0;
      bus_if.HR = 1'b0;
      bus_if.Alarm_Off = 1'b0;
      bus_if.time_match = 1'b0;
      test_reset();
      test_set_clock();
      test_set_alarm();
      test_ring_timeout();
      test_alarm_off();
      test_both_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
